// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the memory stage: funct3 width codes, FSM states,
// and a helper that maps a funct3 size field to a byte count.
package mem_stage_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2
  } lsu_state_e;

  function automatic int unsigned access_bytes(input logic [1:0] size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/grant/response bus between the LSU (master) and memory (slave).
// Requests are held stable until mem_gnt; load data returns later with mem_rvalid.
interface mem_stage_lsu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) ();
  localparam int NBE = XLEN / 8;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [NBE-1:0]    mem_be;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu_align.sv
// Combinational lane logic: byte enables, store-data shift, load extension and
// misalignment/illegal-width detection. Zero latency, no flow control.
module lsu_align
  import mem_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic [2:0]        funct3_i,
  input  logic [XLEN-1:0]   addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [XLEN-1:0]   rdata_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [XLEN/8-1:0] be_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic [XLEN-1:0]   rdata_o,
  output logic              misalign_o
);
  localparam int NBE   = XLEN / 8;
  localparam int OFF_W = $clog2(NBE);

  logic [OFF_W-1:0]        off;
  logic [OFF_W+2:0]        bit_off;
  logic [NBE-1:0]          be_base;
  logic                    unaligned;
  logic                    illegal;
  int unsigned             nbytes;
  int unsigned             sa;
  logic [XLEN-1:0]         shifted;
  logic [XLEN-1:0]         left;
  logic signed [XLEN-1:0]  sext;
  logic [ADDR_W-1:0]       addr_ext;

  assign off     = addr_i[OFF_W-1:0];
  assign bit_off = {off, 3'b000};

  always_comb begin
    be_base   = '0;
    unaligned = 1'b0;
    illegal   = 1'b0;
    nbytes    = access_bytes(funct3_i[1:0]);
    case (funct3_i[1:0])
      2'b00: be_base = NBE'(1);
      2'b01: begin
        be_base   = NBE'(3);
        unaligned = addr_i[0];
      end
      2'b10: begin
        be_base   = NBE'(4'hF);
        unaligned = |addr_i[1:0];
      end
      default: begin
        // Doubleword only exists on RV64; on RV32 clamp the width so the
        // extension shift below stays in range.
        be_base   = '1;
        unaligned = |addr_i[2:0];
        illegal   = (XLEN == 32);
        nbytes    = NBE;
      end
    endcase
    if (funct3_i == 3'b111 || (XLEN == 32 && funct3_i == F3_WU)) begin
      illegal = 1'b1;
    end
  end

  assign misalign_o = unaligned | illegal;
  assign be_o       = be_base << off;
  assign wdata_o    = wdata_i << bit_off;

  assign addr_ext = ADDR_W'(addr_i);
  assign addr_o   = {addr_ext[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  // Move the addressed bytes to the top, then shift back down to extend.
  always_comb begin
    shifted = rdata_i >> bit_off;
    sa      = XLEN - 8 * nbytes;
    left    = shifted << sa;
    sext    = $signed(left) >>> sa;
    if (funct3_i[2]) begin
      rdata_o = left >> sa;
    end else begin
      rdata_o = sext;
    end
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory stage: issues loads/stores over req/gnt/rvalid, stalls the pipeline while
// an access is outstanding, and registers results into the MEM/WB register.
module mem_stage_lsu
  import mem_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWriteM,
  input  logic             MemReadM,
  input  logic             MemWriteM,
  input  logic             ResultSrcM,
  input  logic [2:0]       Funct3M,
  input  logic [4:0]       RD_M,
  input  logic [XLEN-1:0]  PCPlus4M,
  input  logic [XLEN-1:0]  WriteDataM,
  input  logic [XLEN-1:0]  ALU_ResultM,
  mem_stage_lsu_if.master  mem,
  output logic             StallM,
  output logic             RegWriteW,
  output logic             ResultSrcW,
  output logic [4:0]       RD_W,
  output logic [XLEN-1:0]  PCPlus4W,
  output logic [XLEN-1:0]  ReadDataW,
  output logic [XLEN-1:0]  ALU_ResultW,
  output logic             MisalignW
);
  lsu_state_e      state_q, state_d;
  logic            is_mem, mis_raw, misalign, access;
  logic            req, stall;
  logic [XLEN-1:0] load_ext;

  logic            regwrite_q, resultsrc_q, misalign_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] pcplus4_q, readdata_q, aluresult_q;

  lsu_align #(.XLEN(XLEN), .ADDR_W(ADDR_W)) u_align (
    .funct3_i   (Funct3M),
    .addr_i     (ALU_ResultM),
    .wdata_i    (WriteDataM),
    .rdata_i    (mem.mem_rdata),
    .addr_o     (mem.mem_addr),
    .be_o       (mem.mem_be),
    .wdata_o    (mem.mem_wdata),
    .rdata_o    (load_ext),
    .misalign_o (mis_raw)
  );

  assign is_mem   = MemReadM | MemWriteM;
  assign misalign = is_mem & mis_raw;
  assign access   = is_mem & ~mis_raw;

  // IDLE and REQ share rules: M inputs are frozen by the stall, so the
  // request fields are naturally stable while waiting for the grant.
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    stall   = 1'b0;
    case (state_q)
      IDLE, REQ: begin
        if (access) begin
          req = 1'b1;
          if (mem.mem_gnt) begin
            if (MemWriteM) begin
              state_d = IDLE;
            end else begin
              state_d = WAIT_RESP;
              stall   = 1'b1;
            end
          end else begin
            state_d = REQ;
            stall   = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_RESP: begin
        if (mem.mem_rvalid) begin
          state_d = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rst) begin
      req   = 1'b0;
      stall = 1'b0;
    end
  end

  assign mem.mem_req = req;
  assign mem.mem_we  = req & MemWriteM;
  assign StallM      = stall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      regwrite_q  <= 1'b0;
      resultsrc_q <= 1'b0;
      misalign_q  <= 1'b0;
      rd_q        <= '0;
      pcplus4_q   <= '0;
      readdata_q  <= '0;
      aluresult_q <= '0;
    end else begin
      state_q <= state_d;
      if (!stall) begin
        regwrite_q  <= RegWriteM & ~misalign;
        resultsrc_q <= ResultSrcM;
        misalign_q  <= misalign;
        rd_q        <= RD_M;
        pcplus4_q   <= PCPlus4M;
        readdata_q  <= load_ext;
        aluresult_q <= ALU_ResultM;
      end else begin
        regwrite_q <= 1'b0;
        misalign_q <= 1'b0;
      end
    end
  end

  assign RegWriteW   = regwrite_q;
  assign ResultSrcW  = resultsrc_q;
  assign MisalignW   = misalign_q;
  assign RD_W        = rd_q;
  assign PCPlus4W    = pcplus4_q;
  assign ReadDataW   = readdata_q;
  assign ALU_ResultW = aluresult_q;

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Parametrised next-generation memory stage for the pipelined RISC-V core. It sits between the execute-stage output (M signals) and the writeback stage (W signals).
- Adds full RV32/RV64 load/store width handling: LB/LH/LW/LBU/LHU/SB/SH/SW, plus LD/LWU/SD when XLEN=64.
- Drives byte enables and talks to an external variable-latency data memory over a req/gnt/rvalid handshake, stalling the pipeline while an access is outstanding.
- Flags misaligned accesses and registers all results into the MEM/WB register.

Parameters:
- XLEN, 32, data path width; legal values 32 or 64.
- ADDR_W, 32, memory address width.
- NBE, XLEN/8, number of byte enables (derived, not overridable).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- RegWriteM  in  1  register write enable of the instruction in M.
- MemReadM  in  1  instruction in M is a load.
- MemWriteM  in  1  instruction in M is a store.
- ResultSrcM  in  1  writeback select: 1 = load data, 0 = ALU result.
- Funct3M  in  3  load/store width and sign selection.
- RD_M  in  5  destination register index.
- PCPlus4M  in  XLEN  PC+4 of the instruction.
- WriteDataM  in  XLEN  store data, unaligned (in bits [n-1:0]).
- ALU_ResultM  in  XLEN  effective address or ALU result.
- mem_req  out  1  request valid to memory.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  address aligned to an NBE boundary.
- mem_be  out  NBE  byte enables.
- mem_wdata  out  XLEN  lane-shifted store data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  load data valid.
- mem_rdata  in  XLEN  raw aligned load data.
- StallM  out  1  hold F/D/E/M stages this cycle.
- RegWriteW  out  1  registered write enable.
- ResultSrcW  out  1  registered writeback select.
- RD_W  out  5  registered destination index.
- PCPlus4W  out  XLEN  registered PC+4.
- ReadDataW  out  XLEN  registered, extended load data.
- ALU_ResultW  out  XLEN  registered ALU result.
- MisalignW  out  1  registered misaligned-access flag.

Behaviour:
- Reset (rst=0 at a rising edge): FSM goes to IDLE and every W output becomes 0. mem_req, mem_we and StallM go to 0 combinationally while rst=0. Reset overrides any in-flight access; an mem_rvalid arriving afterwards in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT_RESP.
  - IDLE: for an aligned access (MemReadM|MemWriteM), mem_req=1 combinationally in the same cycle.
    - gnt=1 and store: access completes, no stall.
    - gnt=1 and load: go to WAIT_RESP.
    - gnt=0: go to REQ.
  - REQ: hold mem_req/mem_addr/mem_be/mem_wdata stable until gnt, then the same completion rules as IDLE apply.
  - WAIT_RESP: mem_req=0. On mem_rvalid, return to IDLE; the load completes this cycle.
  - mem_rvalid never arrives in the same cycle as its gnt. Minimum load latency is 1 stall cycle.
- StallM = (access requested and not completing this cycle). Store completion = gnt. Load completion = rvalid in WAIT_RESP.
- MEM/WB register:
  - When StallM=0, capture the M inputs; ReadDataW gets the extended mem_rdata.
  - When StallM=1, load a bubble: RegWriteW=0 and MisalignW=0, other fields don't-care (hold).
- Alignment: H needs addr[0]=0; W needs addr[1:0]=0; D needs addr[2:0]=0.
  - On a misaligned access: no mem_req, no stall, MisalignW=1, RegWriteW=0.
- Lanes: off = addr[log2(NBE)-1:0]; mem_addr = addr with low bits cleared.
  - B: be = 1<<off. H: be = 3<<off. W: be = 0xF<<off. D: all ones.
  - mem_wdata = WriteDataM << (8*off).
- Load extend: take bytes (mem_rdata >> 8*off) at the access width.
  - Funct3 000/001/010 (and 011 for D) sign-extend.
  - 100/101/110 zero-extend.
  - 011 and 110 are illegal when XLEN=32: treated as no access, with MisalignW=1.
- Non-memory instruction (MemReadM=MemWriteM=0): passes through with 0 latency and never stalls.

Decomposition:
- Package mem_stage_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU;
  - FSM state encoding (IDLE, REQ, WAIT_RESP).
- One sub-module, lsu_align: purely combinational. It generates byte enables and shifted store data, extends load data, and detects misalignment.
- The top level holds the FSM, the stall logic and the MEM/WB register.

Test Plan:
- Reset mid-load: in WAIT_RESP assert rst=0 for 1 cycle, then rvalid=1 -> all W outputs 0, FSM in IDLE, no writeback of the stale data.
- SW to addr 0x100, data 0xDEADBEEF, gnt held low for 2 cycles -> mem_req high with stable signals for 3 cycles, be=0xF, StallM=1 for 2 cycles, RegWriteW=0 bubbles.
- LB at 0x103, rdata=0x80AA5511, gnt immediate, rvalid 2 cycles later -> be=0x8, ReadDataW=0xFFFFFF80 one cycle after rvalid, StallM=1 for 2 cycles.
- LHU at 0x102, rdata=0xBEEF1234 -> ReadDataW=0x0000BEEF; LH at the same address -> 0xFFFFBEEF.
- LW at 0x101 -> mem_req never asserted, StallM=0, next cycle MisalignW=1 and RegWriteW=0.
- XLEN=64: SD at 0x08, then LWU at 0x0C with rdata=0xFFFFFFFF_00000000 -> SD has be=0xFF; LWU has be=0xF0 and ReadDataW=0x00000000_FFFFFFFF.
